// File: rtl/common_types_pkg.sv
// Shared types for the cache-side memory controller: AXI response codes,
// controller states and a small helper for classifying bus responses.
package common_types_pkg;

    typedef enum logic [1:0] {
        AXI_OKAY   = 2'b00,
        AXI_EXOKAY = 2'b01,
        AXI_SLVERR = 2'b10,
        AXI_DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_RESP    = 3'd5
    } axi_ctrl_state_t;

    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    // Single-word accesses only expect OKAY; EXOKAY is also treated as a fault
    // because exclusive accesses are never issued.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return axi_resp_t'(resp) != AXI_OKAY;
    endfunction

endpackage

// File: rtl/axi_lite_mem_ctrl.sv
// Cache-facing memory controller: accepts one single-word read or write
// request at a time from the cache side and turns it into one AXI4-Lite
// master transaction. The result is held on amif_ready/amif_load until the
// cache acknowledges it with a one-cycle amif_done pulse. Every output is a
// register; the combinational process only computes next values.
module axi_lite_mem_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    // cache side
    input  logic                amif_read,
    input  logic                amif_write,
    input  logic [ADDR_W-1:0]   amif_addr,
    input  logic [DATA_W-1:0]   amif_store,
    input  logic                amif_done,
    output logic                amif_ready,
    output logic [DATA_W-1:0]   amif_load,
    output logic                bus_err,
    // AXI4-Lite read address
    output logic [ADDR_W-1:0]   m_araddr,
    output logic [2:0]          m_arprot,
    output logic                m_arvalid,
    input  logic                m_arready,
    // AXI4-Lite read data
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rvalid,
    output logic                m_rready,
    // AXI4-Lite write address
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [2:0]          m_awprot,
    output logic                m_awvalid,
    input  logic                m_awready,
    // AXI4-Lite write data
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wvalid,
    input  logic                m_wready,
    // AXI4-Lite write response
    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready
);

    import common_types_pkg::*;

    axi_ctrl_state_t state, state_nxt;

    logic              aw_done, aw_done_nxt;
    logic              w_done, w_done_nxt;
    logic [ADDR_W-1:0] araddr_nxt, awaddr_nxt;
    logic [DATA_W-1:0] wdata_nxt, load_nxt;
    logic              arvalid_nxt, rready_nxt;
    logic              awvalid_nxt, wvalid_nxt, bready_nxt;
    logic              ready_nxt, bus_err_nxt;

    logic aw_hs, w_hs, aw_fin, w_fin;

    // Whole-word writes only; protection attributes are fixed.
    assign m_wstrb  = '1;
    assign m_arprot = AXI_PROT_DEFAULT;
    assign m_awprot = AXI_PROT_DEFAULT;

    // AW and W complete independently; "fin" covers an earlier or a current handshake.
    assign aw_hs  = m_awvalid & m_awready;
    assign w_hs   = m_wvalid & m_wready;
    assign aw_fin = aw_done | aw_hs;
    assign w_fin  = w_done | w_hs;

    // Next-state and next-output decode; every register holds its value by default.
    always_comb begin
        state_nxt   = state;
        aw_done_nxt = aw_done;
        w_done_nxt  = w_done;
        araddr_nxt  = m_araddr;
        awaddr_nxt  = m_awaddr;
        wdata_nxt   = m_wdata;
        load_nxt    = amif_load;
        arvalid_nxt = m_arvalid;
        rready_nxt  = m_rready;
        awvalid_nxt = m_awvalid;
        wvalid_nxt  = m_wvalid;
        bready_nxt  = m_bready;
        ready_nxt   = amif_ready;
        bus_err_nxt = bus_err;

        case (state)
            ST_IDLE: begin
                // Reads take priority; a simultaneous write stays pending on
                // the cache side and is picked up after this read retires.
                if (amif_read) begin
                    araddr_nxt  = amif_addr;
                    arvalid_nxt = 1'b1;
                    state_nxt   = ST_RD_ADDR;
                end else if (amif_write) begin
                    awaddr_nxt  = amif_addr;
                    wdata_nxt   = amif_store;
                    awvalid_nxt = 1'b1;
                    wvalid_nxt  = 1'b1;
                    aw_done_nxt = 1'b0;
                    w_done_nxt  = 1'b0;
                    state_nxt   = ST_WR_REQ;
                end
            end

            ST_RD_ADDR: begin
                if (m_arready) begin
                    arvalid_nxt = 1'b0;
                    rready_nxt  = 1'b1;
                    state_nxt   = ST_RD_DATA;
                end
            end

            ST_RD_DATA: begin
                if (m_rvalid) begin
                    // Faulted reads never forward slave data to the cache.
                    load_nxt    = resp_is_err(m_rresp) ? '0 : m_rdata;
                    bus_err_nxt = bus_err | resp_is_err(m_rresp);
                    rready_nxt  = 1'b0;
                    ready_nxt   = 1'b1;
                    state_nxt   = ST_RESP;
                end
            end

            ST_WR_REQ: begin
                if (aw_hs) begin
                    awvalid_nxt = 1'b0;
                end
                if (w_hs) begin
                    wvalid_nxt = 1'b0;
                end
                if (aw_fin && w_fin) begin
                    aw_done_nxt = 1'b0;
                    w_done_nxt  = 1'b0;
                    bready_nxt  = 1'b1;
                    state_nxt   = ST_WR_RESP;
                end else begin
                    aw_done_nxt = aw_fin;
                    w_done_nxt  = w_fin;
                end
            end

            ST_WR_RESP: begin
                if (m_bvalid) begin
                    bready_nxt  = 1'b0;
                    ready_nxt   = 1'b1;
                    load_nxt    = '0;
                    bus_err_nxt = bus_err | resp_is_err(m_bresp);
                    state_nxt   = ST_RESP;
                end
            end

            ST_RESP: begin
                // Requests presented alongside done are not looked at until IDLE.
                if (amif_done) begin
                    ready_nxt = 1'b0;
                    state_nxt = ST_IDLE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, flags and all registered outputs; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            m_araddr   <= '0;
            m_awaddr   <= '0;
            m_wdata    <= '0;
            amif_load  <= '0;
            m_arvalid  <= 1'b0;
            m_rready   <= 1'b0;
            m_awvalid  <= 1'b0;
            m_wvalid   <= 1'b0;
            m_bready   <= 1'b0;
            amif_ready <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            aw_done    <= aw_done_nxt;
            w_done     <= w_done_nxt;
            m_araddr   <= araddr_nxt;
            m_awaddr   <= awaddr_nxt;
            m_wdata    <= wdata_nxt;
            amif_load  <= load_nxt;
            m_arvalid  <= arvalid_nxt;
            m_rready   <= rready_nxt;
            m_awvalid  <= awvalid_nxt;
            m_wvalid   <= wvalid_nxt;
            m_bready   <= bready_nxt;
            amif_ready <= ready_nxt;
            bus_err    <= bus_err_nxt;
        end
    end

endmodule

// File: tb/tb_axi_lite_mem_ctrl.sv
// Bench for axi_lite_mem_ctrl: a behavioural AXI4-Lite memory slave with
// configurable or random per-channel delays, a word-level reference memory,
// and a scoreboard queue filled at request time and drained by a monitor
// whenever the controller presents a result.
module tb_axi_lite_mem_ctrl;

    import common_types_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        amif_read, amif_write, amif_done;
    logic [31:0] amif_addr, amif_store;
    logic        amif_ready, bus_err;
    logic [31:0] amif_load;
    logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
    logic [2:0]  m_arprot, m_awprot;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [1:0]  m_rresp, m_bresp;
    logic [3:0]  m_wstrb;

    always #5 clk = ~clk;

    axi_lite_mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .amif_read(amif_read), .amif_write(amif_write), .amif_addr(amif_addr),
        .amif_store(amif_store), .amif_done(amif_done), .amif_ready(amif_ready),
        .amif_load(amif_load), .bus_err(bus_err),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- environment rules shared by slave and model ----------------
    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic logic [1:0] slv_resp(input logic [31:0] a);
        if (a[15:12] == 4'hE) return AXI_SLVERR;
        if (a[15:12] == 4'hD) return AXI_DECERR;
        return AXI_OKAY;
    endfunction

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        bit          is_rd;
        logic [31:0] addr;
        logic [31:0] load;
        bit          err;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] ref_mem[logic [31:0]];
    bit          ref_err = 1'b0;

    function automatic void model_push(input bit rd, input logic [31:0] a, input logic [31:0] d);
        exp_t        e;
        bit          fault;
        logic [31:0] ld;
        fault   = (a[15:12] == 4'hE) || (a[15:12] == 4'hD);
        ref_err = ref_err | fault;
        if (rd) begin
            if (fault) ld = 32'h0;
            else if (ref_mem.exists(a)) ld = ref_mem[a];
            else ld = dflt(a);
        end else begin
            ld = 32'h0;
            if (!fault) ref_mem[a] = d;
        end
        e.is_rd = rd;
        e.addr  = a;
        e.load  = ld;
        e.err   = ref_err;
        sb_q.push_back(e);
    endfunction

    // ---------------- AXI4-Lite slave ----------------
    logic [31:0] smem[logic [31:0]];
    int ar_d = 0, r_d = 0, aw_d = 0, w_d = 0, b_d = 0;
    bit rand_dly = 1'b0;
    int ar_n = 0, aw_n = 0, w_n = 0;

    function automatic int dly(input int d);
        return rand_dly ? int'($urandom_range(0, 3)) : d;
    endfunction

    localparam int R_IDLE = 0, R_ARW = 1, R_ARHS = 2, R_RW = 3, R_RHS = 4;
    int          rs = R_IDLE;
    int          r_cnt;
    logic [31:0] r_addr;

    task automatic drive_r();
        m_rvalid = 1'b1;
        m_rresp  = slv_resp(r_addr);
        if (slv_resp(r_addr) != AXI_OKAY) m_rdata = 32'hDEAD_BEEF;
        else if (smem.exists(r_addr)) m_rdata = smem[r_addr];
        else m_rdata = dflt(r_addr);
    endtask

    // Read channels: a ready raised at a negedge while valid is high means the
    // handshake happened at the following posedge.
    initial begin
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rs = R_IDLE; m_arready = 1'b0; m_rvalid = 1'b0;
            end else begin
                case (rs)
                    R_IDLE: if (m_arvalid) begin
                        r_addr = m_araddr;
                        r_cnt  = dly(ar_d);
                        if (r_cnt == 0) begin m_arready = 1'b1; rs = R_ARHS; end
                        else rs = R_ARW;
                    end
                    R_ARW: begin
                        chk("araddr_stable", {m_arvalid, m_araddr}, {1'b1, r_addr});
                        r_cnt--;
                        if (r_cnt == 0) begin m_arready = 1'b1; rs = R_ARHS; end
                    end
                    R_ARHS: begin
                        m_arready = 1'b0;
                        ar_n++;
                        chk("arvalid_drop", m_arvalid, 1'b0);
                        chk("rready_up", m_rready, 1'b1);
                        r_cnt = dly(r_d);
                        if (r_cnt == 0) begin drive_r(); rs = R_RHS; end
                        else rs = R_RW;
                    end
                    R_RW: begin
                        r_cnt--;
                        if (r_cnt == 0) begin drive_r(); rs = R_RHS; end
                    end
                    default: begin
                        m_rvalid = 1'b0;
                        chk("rready_drop", m_rready, 1'b0);
                        rs = R_IDLE;
                    end
                endcase
            end
        end
    end

    localparam int W_IDLE = 0, W_BUSY = 1, W_B = 2;
    int          ws = W_IDLE;
    int          aw_cnt, w_cnt, b_cnt;
    bit          aw_got, w_got;
    logic [31:0] w_addr, w_data;

    // Write channels: AW and W are accepted on independent delays.
    initial begin
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ws = W_IDLE; m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
            end else begin
                case (ws)
                    W_IDLE: if (m_awvalid || m_wvalid) begin
                        chk("aw_w_together", {m_awvalid, m_wvalid}, 2'b11);
                        chk("wstrb", m_wstrb, 4'hF);
                        w_addr    = m_awaddr;
                        w_data    = m_wdata;
                        aw_cnt    = dly(aw_d);
                        w_cnt     = dly(w_d);
                        aw_got    = 1'b0;
                        w_got     = 1'b0;
                        m_awready = (aw_cnt == 0);
                        m_wready  = (w_cnt == 0);
                        ws        = W_BUSY;
                    end
                    W_BUSY: begin
                        if (!aw_got) begin
                            if (m_awready) begin
                                m_awready = 1'b0; aw_got = 1'b1; aw_n++;
                                chk("awvalid_drop", m_awvalid, 1'b0);
                            end else begin
                                chk("awaddr_stable", {m_awvalid, m_awaddr}, {1'b1, w_addr});
                                aw_cnt--;
                                if (aw_cnt == 0) m_awready = 1'b1;
                            end
                        end
                        if (!w_got) begin
                            if (m_wready) begin
                                m_wready = 1'b0; w_got = 1'b1; w_n++;
                                chk("wvalid_drop", m_wvalid, 1'b0);
                            end else begin
                                chk("wdata_stable", {m_wvalid, m_wdata}, {1'b1, w_data});
                                w_cnt--;
                                if (w_cnt == 0) m_wready = 1'b1;
                            end
                        end
                        if (aw_got && w_got) begin
                            chk("bready_up", m_bready, 1'b1);
                            b_cnt = dly(b_d);
                            if (b_cnt == 0) begin m_bvalid = 1'b1; m_bresp = slv_resp(w_addr); end
                            ws = W_B;
                        end
                    end
                    default: begin
                        if (m_bvalid) begin
                            m_bvalid = 1'b0;
                            chk("bready_drop", m_bready, 1'b0);
                            if (slv_resp(w_addr) == AXI_OKAY) smem[w_addr] = w_data;
                            ws = W_IDLE;
                        end else begin
                            b_cnt--;
                            if (b_cnt == 0) begin m_bvalid = 1'b1; m_bresp = slv_resp(w_addr); end
                        end
                    end
                endcase
            end
        end
    end

    // ---------------- monitor ----------------
    exp_t mon_e;
    bit   mon_prev = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_prev = 1'b0;
            end else begin
                if (amif_ready && !mon_prev) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_ready", 1'b1, 1'b0);
                    end else begin
                        mon_e = sb_q.pop_front();
                        chk(mon_e.is_rd ? "rd_load" : "wr_load", amif_load, mon_e.load);
                        chk("bus_err", bus_err, mon_e.err);
                    end
                end
                mon_prev = amif_ready;
            end
        end
    end

    // ---------------- cache-side driver ----------------
    int last_lat;

    task automatic issue(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input int hold);
        int a0 = ar_n;
        int aw0 = aw_n;
        int w0 = w_n;
        int cyc = 0;
        int left = int'(rd) + int'(wr);
        if (rd) model_push(1'b1, a, 32'h0);
        if (wr) model_push(1'b0, a, d);
        @(negedge clk);
        amif_addr = a; amif_store = d; amif_read = rd; amif_write = wr;
        last_lat = -1;
        while (left > 0) begin
            @(negedge clk);
            cyc++;
            if (cyc > 200) begin
                chk("txn_timeout", cyc, 0);
                amif_read = 1'b0; amif_write = 1'b0;
                return;
            end
            if (amif_ready) begin
                if (last_lat < 0) last_lat = cyc;
                repeat (hold) @(negedge clk);
                if (hold > 0) chk("ready_held", amif_ready, 1'b1);
                amif_done = 1'b1;
                if (amif_read) amif_read = 1'b0;
                else amif_write = 1'b0;
                left--;
                @(negedge clk);
                amif_done = 1'b0;
                cyc = 0;
            end
        end
        chk("ar_count", ar_n - a0, rd);
        chk("aw_count", aw_n - aw0, wr);
        chk("w_count", w_n - w0, wr);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        amif_read = 1'b0; amif_write = 1'b0; amif_done = 1'b0;
        amif_addr = '0; amif_store = '0;
        repeat (3) @(negedge clk);
        chk("rst_amif_ready", amif_ready, 1'b0);
        chk("rst_amif_load", amif_load, 32'h0);
        chk("rst_bus_err", bus_err, 1'b0);
        chk("rst_valids", {m_arvalid, m_awvalid, m_wvalid}, 3'b000);
        chk("rst_readies", {m_rready, m_bready}, 2'b00);
        chk("rst_regs", {m_araddr, m_awaddr}, 64'h0);
        rst = 1'b0;

        // done pulse while idle must be ignored
        @(negedge clk); amif_done = 1'b1;
        @(negedge clk); amif_done = 1'b0;
        chk("done_idle_ignored", amif_ready, 1'b0);

        // zero-wait read and write latency
        smem[32'h1000] = 32'hCAFE_F00D;
        ref_mem[32'h1000] = 32'hCAFE_F00D;
        issue(1'b1, 1'b0, 32'h0000_1000, 32'h0, 0);
        chk("rd_latency", last_lat, 3);
        issue(1'b0, 1'b1, 32'h0000_3000, 32'hA5A5_0001, 0);
        chk("wr_latency", last_lat, 3);

        // AW accepted 3 cycles ahead of W, then read back
        w_d = 3;
        issue(1'b0, 1'b1, 32'h0000_2004, 32'h1234_5678, 0);
        w_d = 0;
        issue(1'b1, 1'b0, 32'h0000_2004, 32'h0, 0);

        // slow address and data phases
        ar_d = 5; r_d = 4;
        issue(1'b1, 1'b0, 32'h0000_1000, 32'h0, 2);
        ar_d = 0; r_d = 0;

        // faulted read, then sticky error across OKAY traffic
        issue(1'b1, 1'b0, 32'h0000_E000, 32'h0, 0);
        issue(1'b1, 1'b0, 32'h0000_1000, 32'h0, 0);
        issue(1'b0, 1'b1, 32'h0000_2008, 32'h0F0F_0F0F, 1);

        // simultaneous read and write: read first
        issue(1'b1, 1'b1, 32'h0000_0040, 32'h0BAD_CAFE, 1);
        issue(1'b1, 1'b0, 32'h0000_0040, 32'h0, 0);

        // reset while waiting for read data
        r_d = 4;
        @(negedge clk);
        amif_addr = 32'h0000_1000; amif_read = 1'b1;
        begin
            int n;
            n = 0;
            while (!m_rready && n < 50) begin @(negedge clk); n++; end
            chk("reach_rd_data", m_rready, 1'b1);
        end
        rst = 1'b1;
        #1;
        chk("midrst_outputs", {amif_ready, bus_err, m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready}, 7'b0);
        chk("midrst_load", amif_load, 32'h0);
        amif_read = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ref_err = 1'b0;
        r_d = 0;
        issue(1'b1, 1'b0, 32'h0000_1000, 32'h0, 0);

        // randomized traffic with random slave delays
        rand_dly = 1'b1;
        for (int i = 0; i < 40; i++) begin
            int          k;
            int          sel;
            logic [31:0] a;
            k   = int'($urandom_range(0, 9));
            sel = int'($urandom_range(0, 2));
            a   = 32'h0;
            a[15:12] = (k == 0) ? 4'hE : (k == 1) ? 4'hD : (k < 6) ? 4'h1 : 4'h2;
            a[5:2]   = 4'($urandom_range(0, 7));
            issue(sel != 1, sel != 0, a, $urandom, int'($urandom_range(0, 2)));
        end

        repeat (5) @(negedge clk);
        chk("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
